// File: rtl/ds2_pkg.sv
// Shared types and constants for the DualShock pad poller: FSM states,
// poll-frame command bytes, pad ID bytes and the NES button packing.
package ds2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_GAP,
        ST_DESEL,
        ST_CHECK
    } ds2_state_e;

    localparam logic [7:0] ID_DIGITAL = 8'h41;
    localparam logic [7:0] ID_ANALOG  = 8'h73;
    localparam logic [7:0] ID_READY   = 8'h5A;

    localparam logic [2:0] LAST_BYTE = 3'd4;
    localparam logic [2:0] LAST_BIT  = 3'd7;

    localparam int NES_R      = 7;
    localparam int NES_L      = 6;
    localparam int NES_D      = 5;
    localparam int NES_U      = 4;
    localparam int NES_START  = 3;
    localparam int NES_SELECT = 2;
    localparam int NES_B      = 1;
    localparam int NES_A      = 0;

    function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0:    c = 8'h01;
            3'd1:    c = 8'h42;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // Pad bytes are active-low; the NES byte is pressed-high.
    function automatic logic [7:0] nes_map(input logic [7:0] rx3, input logic [7:0] rx4);
        logic [7:0] m;
        m             = '0;
        m[NES_R]      = ~rx3[5];
        m[NES_L]      = ~rx3[7];
        m[NES_D]      = ~rx3[6];
        m[NES_U]      = ~rx3[4];
        m[NES_START]  = ~rx3[3];
        m[NES_SELECT] = ~rx3[0];
        m[NES_B]      = ~rx4[6];
        m[NES_A]      = ~rx4[5];
        return m;
    endfunction

    function automatic logic frame_valid(input logic [7:0] rx1, input logic [7:0] rx2);
        return ((rx1 == ID_DIGITAL) || (rx1 == ID_ANALOG)) && (rx2 == ID_READY);
    endfunction

endpackage

// File: rtl/ds2_tick_gen.sv
// Timing base for the pad poller: free-running poll tick and a restartable
// half-period strobe that paces the pad bus clock.
module ds2_tick_gen #(
    parameter int POLL_DIV = 420000,
    parameter int HALF     = 50
) (
    input  logic clk_p,
    input  logic resetn,
    input  logic restart,
    output logic tick,
    output logic strobe
);

    localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);

    logic [PW-1:0] poll_q, poll_d;
    logic [HW-1:0] half_q, half_d;

    always_comb begin
        tick   = (poll_q == POLL_LAST);
        strobe = (half_q == HALF_LAST);
        poll_d = tick ? '0 : poll_q + 1'b1;
        half_d = (restart || strobe) ? '0 : half_q + 1'b1;
    end

    always_ff @(posedge clk_p) begin
        if (!resetn) begin
            poll_q <= '0;
            half_q <= '0;
        end else begin
            poll_q <= poll_d;
            half_q <= half_d;
        end
    end

endmodule

// File: rtl/ds2_poll_sequencer.sv
// DualShock pad poller: sends the 5-byte digital poll frame on each poll tick,
// validates the reply and publishes button state plus a pad-present flag.
module ds2_poll_sequencer
    import ds2_pkg::*;
#(
    parameter int CLK_HZ     = 25_200_000,
    parameter int SCK_HZ     = 250_000,
    parameter int POLL_HZ    = 60,
    parameter int FAIL_LIMIT = 4
) (
    input  logic        clk_p,
    input  logic        resetn,
    input  logic        poll_en,
    output logic        ps_clk,
    output logic        ps_sel,
    output logic        ps_mosi,
    input  logic        ps_miso,
    output logic [15:0] btn_raw,
    output logic [7:0]  nes_btn,
    output logic        present,
    output logic        frame_done
);

    localparam int HALF     = CLK_HZ / SCK_HZ / 2;
    localparam int POLL_DIV = CLK_HZ / POLL_HZ;
    localparam logic [2:0] FAIL_LIM3 = 3'(FAIL_LIMIT);

    ds2_state_e  state_q, state_d;
    logic [2:0]  byte_q, byte_d;
    logic [2:0]  bit_q, bit_d;
    logic        cnt_q, cnt_d;
    logic        sel_q, sel_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic [31:0] rx_q, rx_d;
    logic [2:0]  fail_q, fail_d;
    logic [15:0] btn_q, btn_d;
    logic [7:0]  nes_q, nes_d;
    logic        present_q, present_d;
    logic        done_q, done_d;

    logic        tick, strobe, restart;
    logic [7:0]  cmd_v;
    logic [2:0]  fail_inc;

    assign restart = (state_d != state_q);

    ds2_tick_gen #(
        .POLL_DIV (POLL_DIV),
        .HALF     (HALF)
    ) u_tick_gen (
        .clk_p   (clk_p),
        .resetn  (resetn),
        .restart (restart),
        .tick    (tick),
        .strobe  (strobe)
    );

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        bit_d     = bit_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        rx_d      = rx_q;
        fail_d    = fail_q;
        btn_d     = btn_q;
        nes_d     = nes_q;
        present_d = present_q;
        done_d    = 1'b0;
        cmd_v     = '0;
        fail_inc  = (fail_q == 3'd7) ? 3'd7 : fail_q + 3'd1;

        case (state_q)
            ST_IDLE: begin
                if (tick && poll_en) begin
                    sel_d   = 1'b0;
                    byte_d  = '0;
                    bit_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP, ST_GAP: begin
                if (strobe) begin
                    if (cnt_q) state_d = ST_LOW;
                    else       cnt_d   = 1'b1;
                end
            end
            ST_LOW: begin
                if (strobe) begin
                    sclk_d  = 1'b1;
                    state_d = ST_HIGH;
                    // Byte 0 of the reply carries nothing useful and is not kept.
                    case (byte_q)
                        3'd1:    rx_d[{2'd0, bit_q}] = ps_miso;
                        3'd2:    rx_d[{2'd1, bit_q}] = ps_miso;
                        3'd3:    rx_d[{2'd2, bit_q}] = ps_miso;
                        3'd4:    rx_d[{2'd3, bit_q}] = ps_miso;
                        default: ;
                    endcase
                end
            end
            ST_HIGH: begin
                if (strobe) begin
                    if (bit_q != LAST_BIT) begin
                        bit_d   = bit_q + 3'd1;
                        state_d = ST_LOW;
                    end else if (byte_q != LAST_BYTE) begin
                        bit_d   = '0;
                        byte_d  = byte_q + 3'd1;
                        mosi_d  = 1'b1;
                        state_d = ST_GAP;
                    end else begin
                        mosi_d  = 1'b1;
                        sel_d   = 1'b1;
                        state_d = ST_DESEL;
                    end
                end
            end
            ST_DESEL: begin
                if (strobe) begin
                    if (cnt_q) state_d = ST_CHECK;
                    else       cnt_d   = 1'b1;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (frame_valid(rx_q[7:0], rx_q[15:8])) begin
                    btn_d     = ~rx_q[31:16];
                    nes_d     = nes_map(rx_q[23:16], rx_q[31:24]);
                    present_d = 1'b1;
                    fail_d    = '0;
                end else begin
                    fail_d = fail_inc;
                    if (fail_inc >= FAIL_LIM3) begin
                        present_d = 1'b0;
                        btn_d     = '0;
                        nes_d     = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) cnt_d = 1'b0;

        // Every entry into LOW drops the bus clock and presents the next command bit.
        if ((state_d == ST_LOW) && (state_q != ST_LOW)) begin
            sclk_d = 1'b0;
            cmd_v  = cmd_byte(byte_d);
            mosi_d = cmd_v[bit_d];
        end
    end

    always_ff @(posedge clk_p) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            byte_q    <= '0;
            bit_q     <= '0;
            cnt_q     <= 1'b0;
            sel_q     <= 1'b1;
            sclk_q    <= 1'b1;
            mosi_q    <= 1'b1;
            rx_q      <= '0;
            fail_q    <= '0;
            btn_q     <= '0;
            nes_q     <= '0;
            present_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            rx_q      <= rx_d;
            fail_q    <= fail_d;
            btn_q     <= btn_d;
            nes_q     <= nes_d;
            present_q <= present_d;
            done_q    <= done_d;
        end
    end

    assign ps_clk     = sclk_q;
    assign ps_sel     = sel_q;
    assign ps_mosi    = mosi_q;
    assign btn_raw    = btn_q;
    assign nes_btn    = nes_q;
    assign present    = present_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_ds2_poll_sequencer.sv
// Self-checking bench for ds2_poll_sequencer: a pad BFM answers each frame and
// a frame-level reference model predicts the published button state.
module tb_ds2_poll_sequencer;

    localparam int CLK_HZ   = 25_200_000;
    localparam int SCK_HZ   = 504_000;
    localparam int POLL_HZ  = 10_000;
    localparam int HALF     = CLK_HZ / SCK_HZ / 2;
    localparam int POLL_DIV = CLK_HZ / POLL_HZ;
    localparam logic [39:0] CMD_VEC = 40'h00_00_00_42_01;

    logic        clk_p   = 1'b0;
    logic        resetn  = 1'b0;
    logic        poll_en = 1'b0;
    logic        ps_miso = 1'b1;
    logic        ps_clk, ps_sel, ps_mosi, present, frame_done;
    logic [15:0] btn_raw;
    logic [7:0]  nes_btn;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [39:0] bfm_resp = '1;
    logic [39:0] mosi_cap = '0;
    int          bfm_idx  = 0;
    logic        bfm_prev_clk = 1'b1;
    logic        bfm_prev_sel = 1'b1;

    logic [15:0] exp_btn;
    logic [7:0]  exp_nes;
    logic        exp_present;
    int          exp_fail;

    ds2_poll_sequencer #(
        .CLK_HZ     (CLK_HZ),
        .SCK_HZ     (SCK_HZ),
        .POLL_HZ    (POLL_HZ),
        .FAIL_LIMIT (4)
    ) dut (
        .clk_p      (clk_p),
        .resetn     (resetn),
        .poll_en    (poll_en),
        .ps_clk     (ps_clk),
        .ps_sel     (ps_sel),
        .ps_mosi    (ps_mosi),
        .ps_miso    (ps_miso),
        .btn_raw    (btn_raw),
        .nes_btn    (nes_btn),
        .present    (present),
        .frame_done (frame_done)
    );

    always #5 clk_p = ~clk_p;

    // Pad model: shifts out the reply LSB first after each falling bus clock
    // and records the command bit present at each rising bus clock.
    always @(posedge clk_p) begin
        #1;
        if (bfm_prev_sel && !ps_sel) bfm_idx = 0;
        if (!ps_sel && bfm_prev_clk && !ps_clk && bfm_idx < 40)
            ps_miso = bfm_resp[bfm_idx[5:0]];
        if (!ps_sel && !bfm_prev_clk && ps_clk && bfm_idx < 40) begin
            mosi_cap[bfm_idx[5:0]] = ps_mosi;
            bfm_idx++;
        end
        if (ps_sel) ps_miso = 1'b1;
        bfm_prev_clk = ps_clk;
        bfm_prev_sel = ps_sel;
    end

    initial begin
        #900_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [39:0] actual, input logic [39:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk_p);
        #1;
        cyc++;
    endtask

    function automatic logic [39:0] mkResp(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3,
                                           input logic [7:0] b4);
        return {b4, b3, b2, b1, b0};
    endfunction

    function automatic logic [39:0] validResp();
        logic [7:0] id;
        id = ($urandom_range(0, 1) == 0) ? 8'h41 : 8'h73;
        return mkResp(8'($urandom), id, 8'h5A, 8'($urandom), 8'($urandom));
    endfunction

    function automatic logic [39:0] randResp();
        logic [7:0] id, rdy;
        case ($urandom_range(0, 3))
            0:       id = 8'h41;
            1:       id = 8'h73;
            2:       id = 8'h41;
            default: id = 8'($urandom);
        endcase
        rdy = ($urandom_range(0, 3) != 0) ? 8'h5A : 8'($urandom);
        return mkResp(8'($urandom), id, rdy, 8'($urandom), 8'($urandom));
    endfunction

    task automatic modelReset();
        exp_btn     = '0;
        exp_nes     = '0;
        exp_present = 1'b0;
        exp_fail    = 0;
    endtask

    // Frame-level rules: a good ID/ready pair publishes inverted buttons,
    // otherwise the failure count grows and clears everything at four.
    task automatic modelFrame(input logic [39:0] r);
        int nes_src [8] = '{37, 38, 24, 27, 28, 30, 31, 29};
        logic [5:0] pos;
        logic [7:0] b1, b2;
        b1 = r[15:8];
        b2 = r[23:16];
        if ((b1 == 8'h41 || b1 == 8'h73) && b2 == 8'h5A) begin
            exp_btn = ~r[39:24];
            for (int k = 0; k < 8; k++) begin
                pos        = 6'(nes_src[k]);
                exp_nes[k] = ~r[pos];
            end
            exp_present = 1'b1;
            exp_fail    = 0;
        end else begin
            if (exp_fail < 7) exp_fail++;
            if (exp_fail >= 4) begin
                exp_btn     = '0;
                exp_nes     = '0;
                exp_present = 1'b0;
            end
        end
    endtask

    task automatic waitSelFall(output int t_sel, output bit ok);
        ok = 1'b0;
        t_sel = cyc;
        for (int i = 0; i < 2 * POLL_DIV + 10; i++) begin
            stepCycle();
            if (!ps_sel) begin
                ok = 1'b1;
                t_sel = cyc;
                break;
            end
        end
        if (!ok) checkOutput("sel_fall_timeout", 1, 0);
    endtask

    task automatic idleWindow(input int n, input string tag);
        int act;
        act = 0;
        for (int i = 0; i < n; i++) begin
            stepCycle();
            if (!ps_sel || frame_done) act++;
        end
        checkOutput(tag, act, 0);
    endtask

    // Runs one whole frame against the given pad reply, checking bus timing,
    // the command stream and the published state against the model.
    task automatic applyStimulus(input logic [39:0] resp, input bit drop_en, output int t_sel);
        bit ok, seen_fall, done_seen, early;
        logic prev_clk, prev_sel;
        logic [15:0] snap_btn;
        logic [7:0]  snap_nes;
        logic        snap_present;
        int t_fall, t_rise, t_selr, first_fall, low_cnt, low_ok, high_h, high_gap;

        bfm_resp = resp;
        waitSelFall(t_sel, ok);
        if (!ok) return;
        if (drop_en) poll_en = 1'b0;

        snap_btn = btn_raw; snap_nes = nes_btn; snap_present = present;
        seen_fall = 0; done_seen = 0; early = 0;
        prev_clk = ps_clk; prev_sel = ps_sel;
        t_fall = 0; t_rise = 0; t_selr = 0; first_fall = 0;
        low_cnt = 0; low_ok = 0; high_h = 0; high_gap = 0;

        for (int i = 0; i < 92 * HALF + 20; i++) begin
            stepCycle();
            if (frame_done) begin
                done_seen = 1;
                break;
            end
            if (prev_clk && !ps_clk) begin
                if (!seen_fall)                  first_fall = cyc - t_sel;
                else if (cyc - t_rise == HALF)     high_h++;
                else if (cyc - t_rise == 3 * HALF) high_gap++;
                seen_fall = 1;
                t_fall = cyc;
            end
            if (!prev_clk && ps_clk) begin
                low_cnt++;
                if (cyc - t_fall == HALF) low_ok++;
                t_rise = cyc;
            end
            if (!prev_sel && ps_sel) t_selr = cyc;
            if (btn_raw !== snap_btn || nes_btn !== snap_nes || present !== snap_present) early = 1;
            prev_clk = ps_clk;
            prev_sel = ps_sel;
        end

        if (!done_seen) begin
            checkOutput("frame_done_timeout", 1, 0);
            return;
        end
        checkOutput("frame_len",    cyc - t_sel, 92 * HALF + 1);
        checkOutput("sel_setup",    first_fall, 2 * HALF);
        checkOutput("low_count",    low_cnt, 40);
        checkOutput("low_width",    low_ok, 40);
        checkOutput("high_width",   high_h, 35);
        checkOutput("gap_width",    high_gap, 4);
        checkOutput("desel_to_done", cyc - t_selr, 2 * HALF + 1);
        checkOutput("mosi_stream",  mosi_cap, CMD_VEC);
        checkOutput("early_change", early, 0);

        modelFrame(resp);
        checkOutput("btn_raw", btn_raw, exp_btn);
        checkOutput("nes_btn", nes_btn, exp_nes);
        checkOutput("present", present, exp_present);
        stepCycle();
        checkOutput("done_pulse", frame_done, 0);
    endtask

    task automatic checkResetOutputs(input string pfx);
        checkOutput({pfx, "_sel"},     ps_sel, 1);
        checkOutput({pfx, "_clk"},     ps_clk, 1);
        checkOutput({pfx, "_mosi"},    ps_mosi, 1);
        checkOutput({pfx, "_btn_raw"}, btn_raw, 0);
        checkOutput({pfx, "_nes_btn"}, nes_btn, 0);
        checkOutput({pfx, "_present"}, present, 0);
        checkOutput({pfx, "_done"},    frame_done, 0);
    endtask

    initial begin
        int t_rel, t_sel, falls;
        bit ok;
        logic prev_clk;
        logic [39:0] r;

        $display("[TB] start: HALF=%0d POLL_DIV=%0d", HALF, POLL_DIV);
        modelReset();
        resetn  = 1'b0;
        poll_en = 1'b1;
        repeat (3) stepCycle();
        checkResetOutputs("reset");

        resetn = 1'b1;
        t_rel  = cyc;
        applyStimulus(mkResp(8'hFF, 8'h41, 8'h5A, 8'hEF, 8'hDF), 0, t_sel);
        checkOutput("first_start", t_sel - t_rel, POLL_DIV);
        checkOutput("upo_nes", nes_btn, 8'h11);
        checkOutput("upo_raw", btn_raw, 16'h2010);
        checkOutput("upo_present", present, 1);
        checkOutput("mosi_byte1", mosi_cap[15:8], 8'h42);

        for (int f = 1; f <= 4; f++) begin
            applyStimulus(mkResp(8'hFF, 8'h00, 8'h5A, 8'($urandom), 8'($urandom)), 0, t_sel);
            if (f == 3) begin
                checkOutput("bad3_nes", nes_btn, 8'h11);
                checkOutput("bad3_present", present, 1);
            end
        end
        checkOutput("bad4_nes", nes_btn, 0);
        checkOutput("bad4_raw", btn_raw, 0);
        checkOutput("bad4_present", present, 0);

        applyStimulus(mkResp(8'hFF, 8'h73, 8'h5A, 8'($urandom), 8'($urandom)), 0, t_sel);
        checkOutput("recover_present", present, 1);

        applyStimulus(validResp(), 1, t_sel);
        idleWindow(3 * POLL_DIV, "poll_en_off_idle");
        poll_en = 1'b1;
        applyStimulus(validResp(), 1, t_sel);
        idleWindow(POLL_DIV, "single_frame_idle");
        poll_en = 1'b1;

        r = mkResp(8'hFF, 8'h41, 8'h5A, 8'h00, 8'h00);
        bfm_resp = r;
        applyStimulus(r, 0, t_sel);
        waitSelFall(t_sel, ok);
        falls = 0;
        prev_clk = ps_clk;
        for (int i = 0; i < 92 * HALF && falls < 22; i++) begin
            stepCycle();
            if (prev_clk && !ps_clk) falls++;
            prev_clk = ps_clk;
        end
        checkOutput("mid_reset_point", falls, 22);
        resetn = 1'b0;
        stepCycle();
        checkResetOutputs("mid_reset");
        modelReset();
        resetn = 1'b1;
        t_rel  = cyc;
        applyStimulus(validResp(), 0, t_sel);
        checkOutput("restart_latency", t_sel - t_rel, POLL_DIV);

        applyStimulus('1, 0, t_sel);
        checkOutput("miso_high_present", present, 1);

        for (int f = 0; f < 5; f++) applyStimulus(randResp(), 0, t_sel);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
